// File: rtl/generador_pkg.sv
// generador_pkg: FSM state encodings and width helper shared by the serial pattern transmitter
package generador_pkg;
  localparam logic [1:0] REPOSO = 2'b00;
  localparam logic [1:0] ENVIANDO = 2'b01;
  localparam logic [1:0] FIN = 2'b10;
  function automatic int ancho_largo(input int ancho);
    return $clog2(ancho) + 1;
  endfunction
endpackage

// File: rtl/generador_secuencia_contador_bit.sv
// contador_bit: bit-time prescaler, ticks on the last of every CICLOS_BIT enabled cycles
module contador_bit #(
  parameter int CICLOS_BIT = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tick
);
  localparam int CW = $clog2(CICLOS_BIT + 1);
  logic [CW-1:0] cnt;
  assign tick = en && cnt == CW'(CICLOS_BIT - 1);
  // counts cycles within the current bit; restarts on tick so it never passes CICLOS_BIT-1
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt <= '0;
    else if (clr || tick) cnt <= '0;
    else if (en) cnt <= cnt + CW'(1);
  end
endmodule

// File: rtl/generador_secuencia.sv
// generador_secuencia: loads a pattern and shifts it out MSB-first; GENERADOR_REPETIR_EN adds the repetir port
module generador_secuencia
  import generador_pkg::*;
#(
  parameter int ANCHO = 8,
  parameter int CICLOS_BIT = 1,
  parameter int LW = ancho_largo(ANCHO)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inicio,
  input  logic [ANCHO-1:0] patron,
  input  logic [LW-1:0]    largo,
`ifdef GENERADOR_REPETIR_EN
  input  logic             repetir,
`endif
  output logic             salida,
  output logic             ocupado,
  output logic             fin
);
  logic [1:0] estado;
  logic [ANCHO-1:0] cap, sh, alineado;
  logic [LW-1:0] idx, len;
  logic tick, rep, valido, ultimo;
`ifdef GENERADOR_REPETIR_EN
  assign rep = repetir;
`else
  assign rep = 1'b0;
`endif
  // the pattern is left-aligned on capture so the next bit is always the MSB of the shift register
  assign valido = inicio && largo != '0 && largo <= LW'(ANCHO);
  assign alineado = patron << (LW'(ANCHO) - largo);
  assign ultimo = tick && idx == '0;
  contador_bit #(.CICLOS_BIT(CICLOS_BIT)) u_contador (
    .clk(clk),
    .reset(reset),
    .clr(estado != ENVIANDO),
    .en(estado == ENVIANDO),
    .tick(tick)
  );
  // Moore FSM with registered outputs; cap keeps the aligned pattern for repeats, sh holds the bits still to send
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado <= REPOSO;
      cap <= '0;
      sh <= '0;
      idx <= '0;
      len <= '0;
      salida <= 1'b0;
      ocupado <= 1'b0;
      fin <= 1'b0;
    end else begin
      case (estado)
        REPOSO: begin
          fin <= 1'b0;
          if (valido) begin
            estado <= ENVIANDO;
            cap <= alineado;
            sh <= alineado << 1;
            len <= largo;
            idx <= largo - LW'(1);
            salida <= alineado[ANCHO-1];
            ocupado <= 1'b1;
          end
        end
        ENVIANDO: begin
          if (ultimo && rep) begin
            sh <= cap << 1;
            idx <= len - LW'(1);
            salida <= cap[ANCHO-1];
            fin <= 1'b1;
          end else if (ultimo) begin
            estado <= FIN;
            salida <= 1'b0;
            ocupado <= 1'b0;
            fin <= 1'b1;
          end else if (tick) begin
            sh <= sh << 1;
            idx <= idx - LW'(1);
            salida <= sh[ANCHO-1];
            fin <= 1'b0;
          end else begin
            fin <= 1'b0;
          end
        end
        FIN: begin
          estado <= REPOSO;
          fin <= 1'b0;
        end
        default: begin
          estado <= REPOSO;
          salida <= 1'b0;
          ocupado <= 1'b0;
          fin <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_generador_secuencia.sv
// tb_generador_secuencia: scoreboard bench for generador_secuencia at CICLOS_BIT=1 and 3
module tb_generador_secuencia;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset1, inicio1, salida1, ocupado1, fin1;
  logic reset3, inicio3, salida3, ocupado3, fin3;
  logic [7:0] patron1, patron3;
  logic [3:0] largo1, largo3;
`ifdef GENERADOR_REPETIR_EN
  logic repetir1 = 1'b0, repetir3 = 1'b0;
`endif
  int errors = 0, checks = 0;
  logic [2:0] q1[$], q3[$];
  generador_secuencia #(.ANCHO(8), .CICLOS_BIT(1)) dut1 (
    .clk(clk), .reset(reset1), .inicio(inicio1), .patron(patron1), .largo(largo1),
`ifdef GENERADOR_REPETIR_EN
    .repetir(repetir1),
`endif
    .salida(salida1), .ocupado(ocupado1), .fin(fin1)
  );
  generador_secuencia #(.ANCHO(8), .CICLOS_BIT(3)) dut3 (
    .clk(clk), .reset(reset3), .inicio(inicio3), .patron(patron3), .largo(largo3),
`ifdef GENERADOR_REPETIR_EN
    .repetir(repetir3),
`endif
    .salida(salida3), .ocupado(ocupado3), .fin(fin3)
  );
  task automatic chk(input string tag, input logic [2:0] act, input logic [2:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: salida/ocupado/fin got %b expected %b", tag, $time, act, exp);
    end
  endtask
  // each cycle's expected {salida,ocupado,fin} is compared away from the rising edge
  always @(negedge clk) begin
    if (q1.size() > 0) chk("d1", {salida1, ocupado1, fin1}, q1.pop_front());
    if (q3.size() > 0) chk("d3", {salida3, ocupado3, fin3}, q3.pop_front());
  end
  task automatic step(input int d, input logic [2:0] e);
    if (d == 1) q1.push_back(e);
    else q3.push_back(e);
    @(posedge clk);
    #2;
  endtask
  task automatic drive(input int d, input logic ini, input logic [7:0] p, input logic [3:0] l);
    if (d == 1) {inicio1, patron1, largo1} = {ini, p, l};
    else {inicio3, patron3, largo3} = {ini, p, l};
  endtask
  task automatic idle(input int d, input int n);
    drive(d, 1'b0, 8'h00, 4'd0);
    for (int i = 0; i < n; i++) step(d, 3'b000);
  endtask
  task automatic send(input int d, input logic [7:0] p, input logic [3:0] l, input bit molestar);
    int c = (d == 1) ? 1 : 3;
    drive(d, 1'b1, p, l);
    step(d, 3'b000);
    for (int i = int'(l) - 1; i >= 0; i--)
      for (int j = 0; j < c; j++) begin
        drive(d, molestar && i == int'(l) - 2 && j == 0, ~p, 4'd2);
        step(d, {p[i], 2'b10});
      end
    drive(d, 1'b0, p, l);
    step(d, 3'b001);
  endtask
  initial begin
    logic [7:0] p;
    logic [3:0] l;
    reset1 = 1'b1;
    reset3 = 1'b1;
    drive(1, 1'b0, 8'h00, 4'd0);
    drive(3, 1'b0, 8'h00, 4'd0);
    repeat (2) @(posedge clk);
    #2;
    chk("rst1", {salida1, ocupado1, fin1}, 3'b000);
    chk("rst3", {salida3, ocupado3, fin3}, 3'b000);
    reset1 = 1'b0;
    reset3 = 1'b0;
    idle(1, 2);
    send(1, 8'b0000_1100, 4'd4, 1'b0);
    send(1, 8'hA5, 4'd8, 1'b1);
    send(1, 8'h01, 4'd1, 1'b0);
    send(1, 8'h80, 4'd8, 1'b0);
    send(1, 8'b0000_0110, 4'd3, 1'b1);
    idle(1, 2);
    drive(1, 1'b1, 8'hFF, 4'd0);
    step(1, 3'b000);
    drive(1, 1'b1, 8'hFF, 4'd9);
    step(1, 3'b000);
    drive(1, 1'b1, 8'hFF, 4'd15);
    step(1, 3'b000);
    idle(1, 3);
    repeat (4) begin
      p = 8'($urandom);
      l = 4'($urandom_range(1, 8));
      send(1, p, l, 1'b1);
    end
    idle(1, 2);
    drive(1, 1'b1, 8'hC3, 4'd8);
    step(1, 3'b000);
    drive(1, 1'b0, 8'h00, 4'd0);
    step(1, 3'b110);
    step(1, 3'b110);
    reset1 = 1'b1;
    #1;
    chk("rst_async", {salida1, ocupado1, fin1}, 3'b000);
    step(1, 3'b000);
    reset1 = 1'b0;
    idle(1, 2);
    send(1, 8'hC3, 4'd8, 1'b0);
    idle(1, 2);
    idle(3, 1);
    send(3, 8'b0000_0101, 4'd3, 1'b1);
    send(3, 8'hB4, 4'd5, 1'b0);
    idle(3, 2);
    drive(3, 1'b1, 8'hFF, 4'd9);
    step(3, 3'b000);
    idle(3, 4);
`ifdef GENERADOR_REPETIR_EN
    repetir1 = 1'b1;
    drive(1, 1'b1, 8'b0000_0010, 4'd2);
    step(1, 3'b000);
    drive(1, 1'b0, 8'h00, 4'd0);
    step(1, 3'b110);
    step(1, 3'b010);
    step(1, 3'b111);
    step(1, 3'b010);
    step(1, 3'b111);
    repetir1 = 1'b0;
    step(1, 3'b010);
    step(1, 3'b001);
    idle(1, 2);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
